// File: rtl/seq_park_clarke_if.sv
// Operand/result handshake bundle for seq_park_clarke.
// With PARKCLARKE_SAT_EN defined, the bundle also carries the sticky ovf flag.
interface seq_park_clarke_if #(
  parameter int N = 32
);
  logic                in_valid;
  logic                in_ready;
  logic                mode;
  logic signed [N-1:0] in_x;
  logic signed [N-1:0] in_y;
  logic signed [N-1:0] cos_th;
  logic signed [N-1:0] sin_th;
  logic                out_valid;
  logic                out_ready;
  logic signed [N-1:0] out_x;
  logic signed [N-1:0] out_y;
  logic signed [N-1:0] out_z;
  logic                busy;
`ifdef PARKCLARKE_SAT_EN
  logic                ovf;
`endif

  modport slave (
    input  in_valid, mode, in_x, in_y, cos_th, sin_th, out_ready,
    output in_ready, out_valid, out_x, out_y, out_z, busy
`ifdef PARKCLARKE_SAT_EN
    , output ovf
`endif
  );

  modport master (
    output in_valid, mode, in_x, in_y, cos_th, sin_th, out_ready,
    input  in_ready, out_valid, out_x, out_y, out_z, busy
`ifdef PARKCLARKE_SAT_EN
    , input ovf
`endif
  );
endinterface

// File: rtl/seq_park_clarke.sv
// Sequential Park/Clarke engine sharing one signed Q-format multiplier (inverse dq->abc, forward ab->dq).
// Optional PARKCLARKE_SAT_EN: saturating add/sub with a sticky ovf flag; otherwise two's-complement wrap.
module seq_park_clarke #(
  parameter int N = 32,
  parameter int Q = 18
) (
  input  logic            clk,
  input  logic            rst_n,
  seq_park_clarke_if.slave bus
);
  localparam int W2 = 2 * N;
  localparam logic [63:0] K_SQ3_2_L   = (64'd8660254 * (64'd1 << Q) + 64'd5000000) / 64'd10000000;
  localparam logic [63:0] K_INV_SQ3_L = (64'd5773503 * (64'd1 << Q) + 64'd5000000) / 64'd10000000;
  localparam logic signed [N-1:0] K_SQ3_2   = N'(K_SQ3_2_L);
  localparam logic signed [N-1:0] K_INV_SQ3 = N'(K_INV_SQ3_L);
`ifdef PARKCLARKE_SAT_EN
  localparam logic signed [N-1:0] S_MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N-1:0] S_MIN = {1'b1, {(N-1){1'b0}}};
`endif

  typedef enum logic [2:0] {S_IDLE, S_0, S_1, S_2, S_3, S_4, S_FIN, S_HOLD} state_t;

  function automatic logic signed [N-1:0] f_addsub(input logic signed [N-1:0] a,
                                                    input logic signed [N-1:0] b,
                                                    input logic sub);
`ifdef PARKCLARKE_SAT_EN
    logic [N:0] s;
    s = sub ? ({a[N-1], a} - {b[N-1], b}) : ({a[N-1], a} + {b[N-1], b});
    if (s[N] != s[N-1]) return s[N] ? S_MIN : S_MAX;
    return s[N-1:0];
`else
    return sub ? (a - b) : (a + b);
`endif
  endfunction

`ifdef PARKCLARKE_SAT_EN
  function automatic logic f_ovf(input logic signed [N-1:0] a,
                                 input logic signed [N-1:0] b,
                                 input logic sub);
    logic [N:0] s;
    s = sub ? ({a[N-1], a} - {b[N-1], b}) : ({a[N-1], a} + {b[N-1], b});
    return s[N] ^ s[N-1];
  endfunction
`endif

  state_t              r_state, w_next;
  logic                r_mode;
  logic signed [N-1:0] r_x, r_y, r_c, r_s;
  logic signed [N-1:0] r_p [5];
  logic signed [N-1:0] r_out_x, r_out_y, r_out_z;
  logic                r_out_valid;

  logic signed [N-1:0] w_ma, w_mb, w_p;
  logic signed [W2-1:0] w_prod;
  logic signed [N-1:0] w_fw_2b, w_fw_sum, w_inv_alpha, w_inv_beta;
  logic signed [N-1:0] w_half, w_neg_half, w_ib, w_ic, w_id, w_iq;
  logic                w_in_ready, w_busy;

  // Full 2N-bit product, arithmetic shift by Q, low N bits kept (floor).
  assign w_prod = W2'(w_ma) * W2'(w_mb);
  assign w_p    = N'(w_prod >>> Q);

  assign w_fw_2b     = f_addsub(r_y, r_y, 1'b0);
  assign w_fw_sum    = f_addsub(r_x, w_fw_2b, 1'b0);
  assign w_inv_alpha = f_addsub(r_p[0], r_p[1], 1'b1);
  assign w_inv_beta  = f_addsub(r_p[2], r_p[3], 1'b0);
  assign w_half      = w_inv_alpha >>> 1;
  assign w_neg_half  = f_addsub('0, w_half, 1'b1);
  assign w_ib        = f_addsub(w_neg_half, r_p[4], 1'b0);
  assign w_ic        = f_addsub(w_neg_half, r_p[4], 1'b1);
  assign w_id        = f_addsub(r_p[1], r_p[2], 1'b0);
  assign w_iq        = f_addsub(r_p[4], r_p[3], 1'b1);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.in_valid) w_next = S_0;
      S_0:     w_next = S_1;
      S_1:     w_next = S_2;
      S_2:     w_next = S_3;
      S_3:     w_next = S_4;
      S_4:     w_next = S_FIN;
      S_FIN:   w_next = S_HOLD;
      S_HOLD:  if (bus.out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_in_ready = (r_state == S_IDLE);
    w_busy     = (r_state != S_IDLE);
    w_ma       = '0;
    w_mb       = '0;
    unique case (r_state)
      S_0: if (r_mode) begin w_ma = K_INV_SQ3; w_mb = w_fw_sum; end
           else        begin w_ma = r_c;       w_mb = r_x;      end
      S_1: if (r_mode) begin w_ma = r_c; w_mb = r_x; end
           else        begin w_ma = r_s; w_mb = r_y; end
      S_2: if (r_mode) begin w_ma = r_s; w_mb = r_p[0]; end
           else        begin w_ma = r_s; w_mb = r_x;    end
      S_3: if (r_mode) begin w_ma = r_s; w_mb = r_x; end
           else        begin w_ma = r_c; w_mb = r_y; end
      S_4: if (r_mode) begin w_ma = r_c;     w_mb = r_p[0];     end
           else        begin w_ma = K_SQ3_2; w_mb = w_inv_beta; end
      default: ;
    endcase
  end

  // NOTE: operand and product registers carry no reset; the FSM never reads them before writing them.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && bus.in_valid) begin
      r_mode <= bus.mode;
      r_x    <= bus.in_x;
      r_y    <= bus.in_y;
      r_c    <= bus.cos_th;
      r_s    <= bus.sin_th;
    end
    unique case (r_state)
      S_0:     r_p[0] <= w_p;
      S_1:     r_p[1] <= w_p;
      S_2:     r_p[2] <= w_p;
      S_3:     r_p[3] <= w_p;
      S_4:     r_p[4] <= w_p;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_x     <= '0;
      r_out_y     <= '0;
      r_out_z     <= '0;
    end else if (r_state == S_FIN) begin
      r_out_valid <= 1'b1;
      r_out_x     <= r_mode ? w_id : w_inv_alpha;
      r_out_y     <= r_mode ? w_iq : w_ib;
      r_out_z     <= r_mode ? '0   : w_ic;
    end else if (r_state == S_HOLD && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef PARKCLARKE_SAT_EN
  logic r_ovf, w_sat_evt;

  // A saturation counts only in the state that consumes the saturated sum.
  always_comb begin
    w_sat_evt = 1'b0;
    unique case (r_state)
      S_0:   w_sat_evt = r_mode & (f_ovf(r_y, r_y, 1'b0) | f_ovf(r_x, w_fw_2b, 1'b0));
      S_4:   w_sat_evt = ~r_mode & f_ovf(r_p[2], r_p[3], 1'b0);
      S_FIN: w_sat_evt = r_mode ? (f_ovf(r_p[1], r_p[2], 1'b0) | f_ovf(r_p[4], r_p[3], 1'b1))
                                : (f_ovf(r_p[0], r_p[1], 1'b1) | f_ovf('0, w_half, 1'b1) |
                                   f_ovf(w_neg_half, r_p[4], 1'b0) | f_ovf(w_neg_half, r_p[4], 1'b1));
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)         r_ovf <= 1'b0;
    else if (w_sat_evt) r_ovf <= 1'b1;
  end

  assign bus.ovf = r_ovf;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.busy      = w_busy;
  assign bus.out_valid = r_out_valid;
  assign bus.out_x     = r_out_x;
  assign bus.out_y     = r_out_y;
  assign bus.out_z     = r_out_z;
endmodule

// File: tb/tb_seq_park_clarke.sv
// Scoreboard bench for seq_park_clarke: directed vectors, backpressure, mid-op reset, overflow.
module tb_seq_park_clarke;
  localparam int N = 32;
  localparam int Q = 18;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seq_park_clarke_if #(.N(N)) bus ();
  seq_park_clarke #(.N(N), .Q(Q)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic signed [N-1:0] x, y, z;
  } exp_t;

  typedef struct {
    logic                mode;
    logic signed [N-1:0] x, y, c, s;
    exp_t                e;
  } vec_t;

  exp_t q_exp[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Monitor: every accepted result is popped and compared against the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (q_exp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=%0d expected=none", bus.out_x);
      end else begin
        exp_t e;
        e = q_exp.pop_front();
        check("out_x", bus.out_x, e.x);
        check("out_y", bus.out_y, e.y);
        check("out_z", bus.out_z, e.z);
      end
    end
  end

  task automatic send(input vec_t v, input bit push);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check("in_ready_timeout", n, 0);
    bus.mode     = v.mode;
    bus.in_x     = v.x;
    bus.in_y     = v.y;
    bus.cos_th   = v.c;
    bus.sin_th   = v.s;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (push) q_exp.push_back(v.e);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (bus.out_valid !== 1'b1 && lat < 20);
  endtask

  task automatic run_txn(input vec_t v);
    int lat;
    send(v, 1'b1);
    wait_valid(lat);
    check("latency", lat, 6);
    @(posedge clk); #1;
    check("valid_drop", bus.out_valid, 0);
  endtask

  vec_t vecs[6];
  vec_t v_bp, v_ovf, v_junk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b0, 262144, 0, 262144, 0, '{262144, -131072, -131072}};
    vecs[1] = '{1'b0, 262144, 0, 0, 262144, '{0, 227023, -227023}};
    vecs[2] = '{1'b1, 262144, -131072, 262144, 0, '{262144, 0, 0}};
    vecs[3] = '{1'b1, 0, 262144, 0, 262144, '{302698, 0, 0}};
    vecs[4] = '{1'b1, 0, 262144, 262144, 0, '{0, 302698, 0}};
    vecs[5] = '{1'b0, -1, 0, 1, 0, '{-1, 1, 1}};
    v_bp    = vecs[1];
    v_junk  = '{1'b1, 12345, -777, 5, 9, '{0, 0, 0}};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.mode      = 1'b0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.cos_th    = '0;
    bus.sin_th    = '0;
    rst_n         = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_out_x", bus.out_x, 0);
    rst_n = 1'b1;

    foreach (vecs[i]) run_txn(vecs[i]);

    // Backpressure: result must sit still while new requests are refused.
    begin
      int lat;
      bus.out_ready = 1'b0;
      send(v_bp, 1'b1);
      bus.mode = 1'b1;
      wait_valid(lat);
      check("bp_latency", lat, 6);
      for (int k = 0; k < 10; k++) begin
        check("bp_out_x", bus.out_x, v_bp.e.x);
        check("bp_out_y", bus.out_y, v_bp.e.y);
        check("bp_out_z", bus.out_z, v_bp.e.z);
        check("bp_valid", bus.out_valid, 1);
        check("bp_in_ready", bus.in_ready, 0);
        bus.in_valid = k[0];
        bus.in_x     = v_junk.x;
        bus.in_y     = v_junk.y;
        @(posedge clk); #1;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_release_valid", bus.out_valid, 0);
      check("bp_release_in_ready", bus.in_ready, 1);
    end

    // Reset while the engine sits in S2.
    send(vecs[0], 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_busy", bus.busy, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_in_ready", bus.in_ready, 1);
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_out_x", bus.out_x, 0);
    check("mid_rst_out_y", bus.out_y, 0);
    check("mid_rst_out_z", bus.out_z, 0);
    rst_n = 1'b1;
    run_txn(vecs[3]);

`ifdef PARKCLARKE_SAT_EN
    check("ovf_clear", bus.ovf, 0);
    v_ovf = '{1'b0, 32'sh7FFFFFFF, 32'sh7FFFFFFF, 262144, -262144,
              '{32'sh7FFFFFFF, -1073741823, -1073741823}};
`else
    v_ovf = '{1'b0, 32'sh7FFFFFFF, 32'sh7FFFFFFF, 262144, -262144, '{-2, 1, 1}};
`endif
    run_txn(v_ovf);
`ifdef PARKCLARKE_SAT_EN
    check("ovf_set", bus.ovf, 1);
`endif

    repeat (2) @(posedge clk);
    check("scoreboard_empty", q_exp.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_park_clarke.md
Name: seq_park_clarke

Overview:
- Time-multiplexed, bidirectional combined Park/Clarke transform engine for the FOC current path.
- Inverse mode: dq frame -> three-phase abc. Forward mode: measured phase currents ab -> dq.
- One shared signed fixed-point multiplier, sequenced by an FSM.
- Valid/ready handshakes on both sides; parametrised word width and fraction bits.

Parameters:
- N, 32: word width; all data ports are two's-complement.
- Q, 18: fractional bits; 1.0 = 2^Q.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  input operands valid.
- in_ready  out  1  engine can accept an operand set.
- mode  in  1  0 = inverse (id,iq -> ia,ib,ic); 1 = forward (ia,ib -> id,iq).
- in_x  in  N  inverse: id; forward: ia.
- in_y  in  N  inverse: iq; forward: ib.
- cos_th  in  N  cos(theta), Q format.
- sin_th  in  N  sin(theta), Q format.
- out_valid  out  1  results valid.
- out_ready  in  1  consumer accepts results.
- out_x  out  N  inverse: ia; forward: id.
- out_y  out  N  inverse: ib; forward: iq.
- out_z  out  N  inverse: ic; forward: 0.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Multiply: p = (a*b) formed at 2N bits, arithmetic shift right by Q, low N bits kept (truncate toward -inf).
- Adds/subtracts are N-bit.
- Constants, rounded to nearest:
  - K_SQ3_2 = round(0.8660254*2^Q)
  - K_INV_SQ3 = round(0.5773503*2^Q)
- 0.5*x is an arithmetic right shift by 1.
- Inverse sequence:
  - M0 c*d; M1 s*q; M2 s*d; M3 c*q.
  - alpha = M0-M1; beta = M2+M3.
  - M4 K_SQ3_2*beta.
  - ia = alpha; ib = -(alpha>>>1)+M4; ic = -(alpha>>>1)-M4.
- Forward sequence:
  - alpha = ia.
  - M0 K_INV_SQ3*(ia+2*ib) = beta.
  - M1 c*alpha; M2 s*beta; M3 s*alpha; M4 c*beta.
  - id = M1+M2; iq = M4-M3; out_z = 0.
- FSM states: IDLE -> S0 -> S1 -> S2 -> S3 -> S4 -> FIN -> HOLD -> IDLE.
  - One multiply per state S0..S4; product registered on that state's exiting edge.
  - FIN registers the outputs and sets out_valid.
- in_ready = (state==IDLE), combinational from state.
- Acceptance: edge with in_valid & in_ready. That edge latches in_x, in_y, cos_th, sin_th and mode into internal registers. Later input changes are ignored.
- Latency: out_valid rises on the 6th edge after the acceptance edge.
- HOLD:
  - out_x/y/z and out_valid stay stable while out_ready=0.
  - Edge with out_ready=1: out_valid->0, state->IDLE.
- Throughput: one transform per 8 cycles when out_ready is tied high.
- in_valid while busy is ignored and causes no loss of the current result.
- A mode change mid-operation has no effect; the latched mode is used.
- Reset (rst_n=0 at an edge), regardless of state:
  - state = IDLE, out_valid = 0, out_x = out_y = out_z = 0, busy = 0, in_ready = 1 after that edge.
  - In-flight data is discarded.

Optional Feature:
- Macro: PARKCLARKE_SAT_EN.
- Defined:
  - Every add/subtract and final output saturates to +(2^(N-1)-1) / -2^(N-1).
  - Extra output port ovf (1 bit) is a sticky flag, set on any saturation event.
  - ovf is cleared only by reset; reset value 0.
- Undefined:
  - Two's-complement wrap.
  - No ovf port.

Test Plan:
- Inverse, theta=0 (cos=262144, sin=0), id=262144, iq=0 -> out_x=262144, out_y=-131072, out_z=-131072; out_valid 6 edges after accept.
- Inverse, theta=90deg (cos=0, sin=262144), id=262144, iq=0 -> out_x=0, out_y=227023, out_z=-227023.
- Forward, theta=0, ia=262144, ib=-131072 -> out_x=262144, out_y=0, out_z=0.
- Backpressure: out_ready low 10 cycles after out_valid -> outputs constant, in_ready=0, in_valid pulses ignored. Then out_ready=1 for one edge -> out_valid=0 and in_ready=1 after that edge.
- Reset mid-operation: rst_n low at an edge while in S2 -> after that edge busy=0, in_ready=1, out_valid=0, outputs 0. A new transaction then completes correctly.
- Overflow, inverse: cos=262144, sin=-262144, id=iq=0x7FFFFFFF.
  - With PARKCLARKE_SAT_EN: out_x=0x7FFFFFFF, ovf=1.
  - Without it: out_x=0xFFFFFFFE.
